// File: rtl/hit_capture_pkg.sv
// Shared defaults and event-word layout for hit_capture and its FIFO.
// Event word, LSB first: octave, note, length, clock, then kind (release builds only).
package hit_capture_pkg;

    localparam int HC_NOTE_KEYS   = 7;
    localparam int HC_LENGTH_KEYS = 7;
    localparam int HC_OCT_BITS    = 3;
    localparam int HC_OCT_MAX     = 6;
    localparam int HC_OCT_INIT    = 4;
    localparam int HC_CLK_BITS    = 32;
    localparam int HC_DEPTH       = 8;

    typedef enum logic {
        EV_PRESS   = 1'b0,
        EV_RELEASE = 1'b1
    } ev_kind_t;

    typedef enum int {
        FLD_OCT  = 0,
        FLD_NOTE = 1,
        FLD_LEN  = 2,
        FLD_CLK  = 3,
        FLD_KIND = 4
    } ev_field_e;

    function automatic int field_lo(input ev_field_e f, input int oct_w, input int note_w,
                                    input int len_w, input int clk_w);
        case (f)
            FLD_OCT:  return 0;
            FLD_NOTE: return oct_w;
            FLD_LEN:  return oct_w + note_w;
            FLD_CLK:  return oct_w + note_w + len_w;
            default:  return oct_w + note_w + len_w + clk_w;
        endcase
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int lowest_set(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/hit_capture_event_fifo.sv
// First-word-fall-through event queue with occupancy count.
// Latency: a push is visible on pop_dat/!empty right after its edge.
// Backpressure: push while full is accepted only alongside a pop; otherwise ignored.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hit_capture.sv
// Timestamped key-hit capture into an event FIFO; HIT_RELEASE_EN adds release events.
// Latency: an edge seen at clock k shows on ev_valid right after k when the queue is empty.
// Backpressure: ev_valid/ev_ready; events arriving to a full queue without a pop are dropped, overflow sticks.
module hit_capture
    import hit_capture_pkg::*;
#(
    parameter int NOTE_KEYS   = HC_NOTE_KEYS,
    parameter int LENGTH_KEYS = HC_LENGTH_KEYS,
    parameter int OCT_BITS    = HC_OCT_BITS,
    parameter int OCT_MAX     = HC_OCT_MAX,
    parameter int OCT_INIT    = HC_OCT_INIT,
    parameter int CLK_BITS    = HC_CLK_BITS,
    parameter int DEPTH       = HC_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           oct_up,
    input  logic                           oct_down,
    input  logic [NOTE_KEYS-1:0]           note_key,
    input  logic [LENGTH_KEYS-1:0]         length_key,
    input  logic [CLK_BITS-1:0]            system_clock,
    output logic                           ev_valid,
    input  logic                           ev_ready,
    output logic [OCT_BITS-1:0]            ev_octave,
    output logic [$clog2(NOTE_KEYS)-1:0]   ev_note,
    output logic [$clog2(LENGTH_KEYS)-1:0] ev_length,
    output logic [CLK_BITS-1:0]            ev_clock,
    output logic                           ev_release,
    output logic [OCT_BITS-1:0]            octave,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow
);

    localparam int NOTE_W  = $clog2(NOTE_KEYS);
    localparam int LEN_W   = $clog2(LENGTH_KEYS);
    localparam int OCT_LO  = field_lo(FLD_OCT,  OCT_BITS, NOTE_W, LEN_W, CLK_BITS);
    localparam int NOTE_LO = field_lo(FLD_NOTE, OCT_BITS, NOTE_W, LEN_W, CLK_BITS);
    localparam int LEN_LO  = field_lo(FLD_LEN,  OCT_BITS, NOTE_W, LEN_W, CLK_BITS);
    localparam int CLK_LO  = field_lo(FLD_CLK,  OCT_BITS, NOTE_W, LEN_W, CLK_BITS);
`ifdef HIT_RELEASE_EN
    localparam int KIND_LO = field_lo(FLD_KIND, OCT_BITS, NOTE_W, LEN_W, CLK_BITS);
    localparam int KIND_W  = 1;
`else
    localparam int KIND_W  = 0;
`endif
    localparam int EV_W = field_lo(FLD_KIND, OCT_BITS, NOTE_W, LEN_W, CLK_BITS) + KIND_W;

    logic                   en_q;
    logic                   oct_up_q;
    logic                   oct_down_q;
    logic [NOTE_KEYS-1:0]   note_q;
    logic [LEN_W-1:0]       length_cur;
    logic [CLK_BITS-1:0]    base;

    logic                   en_rise;
    logic                   up_rise;
    logic                   dn_rise;
    logic [NOTE_KEYS-1:0]   note_rise;
    logic                   press;
    logic [CLK_BITS-1:0]    base_eff;
    logic                   push;
    logic [EV_W-1:0]        push_dat;
    logic                   pop;
    logic [EV_W-1:0]        head;
    logic                   full;
    logic                   empty;
    logic                   drop;
`ifdef HIT_RELEASE_EN
    logic [NOTE_KEYS-1:0]   note_fall;
`endif

    always_comb begin
        en_rise   = en & ~en_q;
        up_rise   = oct_up & ~oct_up_q;
        dn_rise   = oct_down & ~oct_down_q;
        note_rise = note_key & ~note_q;
        press     = en && (note_rise != '0);
        // An event on the enabling edge itself is measured against the base latched there.
        base_eff  = en_rise ? system_clock : base;
        push      = press;
        push_dat  = '0;
        push_dat[OCT_LO  +: OCT_BITS] = octave;
        push_dat[LEN_LO  +: LEN_W]    = length_cur;
        push_dat[CLK_LO  +: CLK_BITS] = system_clock - base_eff;
        push_dat[NOTE_LO +: NOTE_W]   = NOTE_W'(lowest_set(64'(note_rise)));
`ifdef HIT_RELEASE_EN
        note_fall = ~note_key & note_q;
        if (!press && en && (note_fall != '0)) begin
            push = 1'b1;
            push_dat[NOTE_LO +: NOTE_W] = NOTE_W'(lowest_set(64'(note_fall)));
            push_dat[KIND_LO]           = EV_RELEASE;
        end
`endif
    end

    assign pop  = ev_valid && ev_ready;
    assign drop = push && full && !pop;

    event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Storage is unreset, so the payload is forced to zero whenever nothing is queued.
    assign ev_valid  = !empty;
    assign ev_octave = ev_valid ? head[OCT_LO  +: OCT_BITS] : '0;
    assign ev_note   = ev_valid ? head[NOTE_LO +: NOTE_W]   : '0;
    assign ev_length = ev_valid ? head[LEN_LO  +: LEN_W]    : '0;
    assign ev_clock  = ev_valid ? head[CLK_LO  +: CLK_BITS] : '0;
`ifdef HIT_RELEASE_EN
    assign ev_release = ev_valid && head[KIND_LO];
`else
    assign ev_release = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            oct_up_q   <= 1'b0;
            oct_down_q <= 1'b0;
            note_q     <= '0;
            length_cur <= '0;
            octave     <= OCT_BITS'(OCT_INIT);
            base       <= '0;
            overflow   <= 1'b0;
        end else begin
            en_q       <= en;
            oct_up_q   <= oct_up;
            oct_down_q <= oct_down;
            note_q     <= note_key;
            if (length_key != '0) length_cur <= LEN_W'(lowest_set(64'(length_key)));
            if (up_rise && !dn_rise && octave != OCT_BITS'(OCT_MAX))
                octave <= octave + OCT_BITS'(1);
            else if (dn_rise && !up_rise && octave != '0)
                octave <= octave - OCT_BITS'(1);
            base     <= en ? base_eff : '0;
            overflow <= (en_rise ? 1'b0 : overflow) | drop;
        end
    end

endmodule

// File: tb/tb_hit_capture.sv
// Directed bench for hit_capture: reset, octave stepping, timestamps, FIFO full/overflow, async reset.
// Release-event steps are compiled only with HIT_RELEASE_EN.
module tb_hit_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        oct_up;
    logic        oct_down;
    logic [6:0]  note_key;
    logic [6:0]  length_key;
    logic [31:0] system_clock;
    logic        ev_valid;
    logic        ev_ready;
    logic [2:0]  ev_octave;
    logic [2:0]  ev_note;
    logic [2:0]  ev_length;
    logic [31:0] ev_clock;
    logic        ev_release;
    logic [2:0]  octave;
    logic [3:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    hit_capture dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .oct_up       (oct_up),
        .oct_down     (oct_down),
        .note_key     (note_key),
        .length_key   (length_key),
        .system_clock (system_clock),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_octave    (ev_octave),
        .ev_note      (ev_note),
        .ev_length    (ev_length),
        .ev_clock     (ev_clock),
        .ev_release   (ev_release),
        .octave       (octave),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int n);
        note_key = 7'(1 << n);
        tick();
        note_key = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; oct_up = 1'b0; oct_down = 1'b0;
        note_key = '0; length_key = '0; system_clock = '0; ev_ready = 1'b0;
        tick();
        tick();
        check("rst_octave",   octave,     3'd4);
        check("rst_count",    count,      4'd0);
        check("rst_valid",    ev_valid,   1'b0);
        check("rst_overflow", overflow,   1'b0);
        check("rst_note",     ev_note,    3'd0);
        check("rst_clock",    ev_clock,   32'd0);
        check("rst_release",  ev_release, 1'b0);
        rst = 1'b0;

        // Octave stepping with capture disabled
        repeat (7) begin oct_up = 1'b1; tick(); oct_up = 1'b0; tick(); end
        check("oct_sat_hi", octave, 3'd6);
        oct_up = 1'b1; oct_down = 1'b1; tick();
        check("oct_both", octave, 3'd6);
        oct_up = 1'b0; oct_down = 1'b0; tick();
        repeat (8) begin oct_down = 1'b1; tick(); oct_down = 1'b0; tick(); end
        check("oct_sat_lo", octave, 3'd0);
        oct_up = 1'b1; repeat (3) tick(); oct_up = 1'b0; tick();
        check("oct_level_once", octave, 3'd1);
        press(2);
        check("no_push_en0", ev_valid, 1'b0);

        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_octave", octave, 3'd4);

        // First event: base 100, press at 105
        en = 1'b1; system_clock = 32'd100; tick();
        note_key = 7'b0000100; system_clock = 32'd105; tick();
        check("ev1_valid",   ev_valid,   1'b1);
        check("ev1_note",    ev_note,    3'd2);
        check("ev1_octave",  ev_octave,  3'd4);
        check("ev1_length",  ev_length,  3'd0);
        check("ev1_clock",   ev_clock,   32'd5);
        check("ev1_count",   count,      4'd1);
        check("ev1_release", ev_release, 1'b0);
        note_key = '0; ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        check("ev1_popped_valid", ev_valid, 1'b0);
        check("ev1_popped_count", count,    4'd0);

        // Payload uses pre-edge octave and held length
        length_key = 7'b0101000; tick();
        length_key = '0; tick();
        note_key = 7'b0000001; oct_up = 1'b1; system_clock = 32'd200; tick();
        check("ev2_octave", ev_octave, 3'd4);
        check("ev2_length", ev_length, 3'd3);
        check("ev2_note",   ev_note,   3'd0);
        check("ev2_clock",  ev_clock,  32'd100);
        check("ev2_octnow", octave,    3'd5);
        note_key = '0; oct_up = 1'b0; ev_ready = 1'b1; tick(); ev_ready = 1'b0;

        // Nine presses into an eight-deep queue
        for (int i = 0; i < 9; i++) press(i % 7);
        check("ovf_count", count,    4'd8);
        check("ovf_flag",  overflow, 1'b1);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pop_order%0d", i), ev_note, 64'(i % 7));
            tick();
        end
        ev_ready = 1'b0;
        check("drained_count", count,    4'd0);
        check("ovf_sticky",    overflow, 1'b1);

        // Overflow clears on enable rise; push into full queue with a pop is accepted
        en = 1'b0; tick();
        en = 1'b1; tick();
        check("ovf_clear", overflow, 1'b0);
        for (int i = 0; i < 8; i++) press(i % 7);
        check("full_count", count, 4'd8);
        note_key = 7'b0001000; ev_ready = 1'b1; tick();
        check("full_pushpop_count", count,    4'd8);
        check("full_pushpop_ovf",   overflow, 1'b0);
        check("full_pushpop_head",  ev_note,  3'd1);
        note_key = '0; ev_ready = 1'b0; tick();
        press(5);
        check("full_drop_count", count,    4'd8);
        check("full_drop_ovf",   overflow, 1'b1);
        ev_ready = 1'b1; repeat (7) tick();
        check("tail_note", ev_note, 3'd3);
        tick(); ev_ready = 1'b0;
        check("tail_count", count, 4'd0);

        // Timestamp wrap-around and top length key
        length_key = 7'b1000000; tick();
        length_key = '0; en = 1'b0; tick();
        en = 1'b1; system_clock = 32'hFFFF_FFF0; tick();
        check("wrap_ovf_clear", overflow, 1'b0);
        note_key = 7'b0100000; system_clock = 32'h0000_0010; tick();
        check("wrap_clock",   ev_clock,   32'h20);
        check("wrap_note",    ev_note,    3'd5);
        check("wrap_length",  ev_length,  3'd6);
        check("wrap_release", ev_release, 1'b0);
        ev_ready = 1'b1; note_key = '0; tick(); ev_ready = 1'b0;
        note_key = 7'b1010000; tick();
        check("multi_rise_note", ev_note, 3'd4);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        check("multi_rise_count", count, 4'd0);

        // Disabled capture, then press on the enabling edge
        en = 1'b0; note_key = 7'b0000001; tick();
        check("no_push_en0_b", ev_valid, 1'b0);
        note_key = 7'b0000011; en = 1'b1; system_clock = 32'd500; tick();
        check("en_edge_note",  ev_note,  3'd1);
        check("en_edge_clock", ev_clock, 32'd0);
        note_key = '0; tick();
        note_key = 7'b0000100; tick();
        check("midq_count", count, 4'd2);

        // Asynchronous reset discards the queue without waiting for a clock
        rst = 1'b1; #1;
        check("rst_async_valid", ev_valid, 1'b0);
        check("rst_async_count", count,    4'd0);
        check("rst_async_oct",   octave,   3'd4);
        tick(); rst = 1'b0;

`ifdef HIT_RELEASE_EN
        note_key = '0; tick();
        note_key = 7'b0001000; tick();
        note_key = '0; tick();
        check("rel_count",      count,      4'd2);
        check("rel_first_note", ev_note,    3'd3);
        check("rel_first_kind", ev_release, 1'b0);
        ev_ready = 1'b1; tick();
        check("rel_second_note", ev_note,    3'd3);
        check("rel_second_kind", ev_release, 1'b1);
        tick(); ev_ready = 1'b0;
        check("rel_drained", count, 4'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_capture.md
HIT_CAPTURE -- requirements
Module: hit_capture

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; parameters as listed below (name, default, meaning).
REQ-002 NOTE_KEYS, 7, number of note key inputs.
REQ-003 LENGTH_KEYS, 7, number of length key inputs.
REQ-004 OCT_BITS, 3, octave width; OCT_MAX, 6, highest octave; OCT_INIT, 4, octave after reset.
REQ-005 CLK_BITS, 32, timestamp width; DEPTH, 8, event FIFO depth, power of two >= 2.
REQ-006 Ports SHALL be (name, direction, width, meaning):
clk  in  1  system clock
rst  in  1  async active-high reset
en  in  1  capture enable; session runs while high
oct_up / oct_down  in  1  octave step requests, level
note_key  in  NOTE_KEYS  note keys, bit i = note i
length_key  in  LENGTH_KEYS  length keys, bit i = length i
system_clock  in  CLK_BITS  free-running time base
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head
ev_octave / ev_note / ev_length  out  OCT_BITS / clog2(NOTE_KEYS) / clog2(LENGTH_KEYS)  head payload
ev_clock  out  CLK_BITS  head timestamp, session-relative
ev_release  out  1  head is a release event
octave  out  OCT_BITS  current octave
count  out  clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky event-dropped flag

Function
REQ-007 All inputs SHALL be treated as synchronous to clk; each key/step input is registered once for edge detection.
REQ-008 Octave SHALL step +1 on an oct_up rising edge and -1 on an oct_down rising edge, saturating at OCT_MAX and 0; both rising in one cycle -> no change.
REQ-009 Current length SHALL update to the lowest set index of length_key each cycle length_key != 0, and hold when length_key == 0; all LENGTH_KEYS bits are covered.
REQ-010 A press event SHALL occur in a cycle where (note_key & ~note_key_q) != 0 and en = 1; ev_note = lowest newly-risen index.
REQ-011 Payload SHALL use octave and length as registered before that edge (a same-cycle octave step affects the next event only).
REQ-012 On en rising, base SHALL latch system_clock; ev_clock = (system_clock - base) mod 2^CLK_BITS, so wrap-around of system_clock yields a correct difference.
REQ-013 While en = 0, no events SHALL be pushed and base SHALL be held at 0; edge registers and octave keep tracking.
REQ-014 The FIFO SHALL be first-word-fall-through: an event detected at edge k SHALL drive ev_valid = 1 right after edge k when the FIFO was empty.
REQ-015 Pop SHALL occur when ev_valid & ev_ready; head payload SHALL be stable while ev_valid = 1 and ev_ready = 0.
REQ-016 Push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the event is dropped and overflow set.
REQ-017 overflow SHALL clear only on rst or en rising.
REQ-018 count SHALL equal entries held, 0..DEPTH; simultaneous push and pop SHALL leave count unchanged.

Reset
REQ-019 rst SHALL asynchronously set octave = OCT_INIT, current length = 0, base = 0, edge registers = 0, FIFO empty, count = 0, ev_valid = 0, overflow = 0.
REQ-020 Payload outputs SHALL read 0 while empty after reset; rst mid-session discards all queued events.

Configuration
REQ-021 With HIT_RELEASE_EN defined, falling note edges SHALL push release events (ev_release = 1, ev_note = lowest fallen index); press has priority in the same cycle, and the release is dropped without setting overflow.
REQ-022 Without HIT_RELEASE_EN, ev_release SHALL be tied 0 and no release logic or storage bit SHALL exist.

Structure
REQ-023 Default widths (OCT_BITS, CLK_BITS, key counts) and event field layout SHALL live in the shared constants header.
REQ-024 Storage SHALL be one sub-module event_fifo (parametrised width/depth, FWFT, push/pop/full/empty/count).

Verification
REQ-025 Reset, en = 1 at system_clock = 100, note_key 0 -> 0000100 at system_clock = 105 -> ev_valid = 1 next cycle, ev_note = 2, ev_octave = 4, ev_length = 0, ev_clock = 5.
REQ-026 Seven oct_up pulses from reset -> octave 6; oct_up + oct_down same cycle -> unchanged; eight oct_down pulses -> 0.
REQ-027 ev_ready = 0, nine distinct presses -> count = 8, overflow = 1, first eight notes popped in order.
REQ-028 Full FIFO, press with ev_ready = 1 same cycle -> count stays 8, overflow = 0.
REQ-029 base = 0xFFFFFFF0, press at system_clock = 0x10 -> ev_clock = 0x20.
REQ-030 HIT_RELEASE_EN: press then release note 3 -> two events, ev_release 0 then 1; rst asserted mid-queue -> ev_valid = 0, count = 0 immediately.
